// File: rtl/ledger_writer.sv
// Ledger write-back: reads sender/receiver records, checks funds/overflow, debits and credits, writes both back.
// Latency: done at start+7 on success, start+5 on error; start is ignored whenever busy.
module ledger_writer #(
    parameter int ADDR_W  = 5,
    parameter int MONEY_W = 8,
    parameter int TAG_W   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        sender_addr,
    input  logic [ADDR_W-1:0]        receiver_addr,
    input  logic [MONEY_W-1:0]       amount,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [TAG_W+MONEY_W-1:0] mem_wdata,
    output logic                     mem_we,
    input  logic [TAG_W+MONEY_W-1:0] mem_rdata,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               status
);
    localparam int WORD_W = TAG_W + MONEY_W;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_SND, S_RD_RCV, S_WAIT_RCV, S_CHECK, S_WR_SND, S_WR_RCV, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   snd_addr_q, snd_addr_d;
    logic [ADDR_W-1:0]   rcv_addr_q, rcv_addr_d;
    logic [MONEY_W-1:0]  amount_q, amount_d;
    logic [WORD_W-1:0]   snd_word_q, snd_word_d;
    logic [WORD_W-1:0]   rcv_word_q, rcv_word_d;
    logic [1:0]          status_q, status_d;
    logic [MONEY_W:0]    rcv_sum;
    logic [MONEY_W-1:0]  snd_money;

    assign snd_money = snd_word_q[MONEY_W-1:0];
    // Carry bit of the widened sum flags receiver overflow
    assign rcv_sum   = {1'b0, rcv_word_q[MONEY_W-1:0]} + {1'b0, amount_q};
    assign busy      = (state_q != S_IDLE);
    assign status    = status_q;

    always_comb begin
        state_d    = state_q;
        snd_addr_d = snd_addr_q;
        rcv_addr_d = rcv_addr_q;
        amount_d   = amount_q;
        snd_word_d = snd_word_q;
        rcv_word_d = rcv_word_q;
        status_d   = status_q;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snd_addr_d = sender_addr;
                    rcv_addr_d = receiver_addr;
                    amount_d   = amount;
                    status_d   = 2'b00;
                    state_d    = S_RD_SND;
                end
            end
            S_RD_SND: begin
                mem_addr = snd_addr_q;
                state_d  = S_RD_RCV;
            end
            S_RD_RCV: begin
                mem_addr   = rcv_addr_q;
                snd_word_d = mem_rdata;
                state_d    = S_WAIT_RCV;
            end
            S_WAIT_RCV: begin
                rcv_word_d = mem_rdata;
                state_d    = S_CHECK;
            end
            S_CHECK: begin
                state_d = S_DONE;
                if (snd_addr_q == rcv_addr_q) begin
                    status_d = 2'b11;
                end else if (snd_money < amount_q) begin
                    status_d = 2'b01;
                end else if (rcv_sum[MONEY_W]) begin
                    status_d = 2'b10;
                end else begin
                    status_d = 2'b00;
                    state_d  = S_WR_SND;
                end
            end
            S_WR_SND: begin
                mem_addr  = snd_addr_q;
                mem_we    = 1'b1;
                mem_wdata = {snd_word_q[WORD_W-1:MONEY_W], snd_money - amount_q};
                state_d   = S_WR_RCV;
            end
            S_WR_RCV: begin
                mem_addr  = rcv_addr_q;
                mem_we    = 1'b1;
                mem_wdata = {rcv_word_q[WORD_W-1:MONEY_W], rcv_sum[MONEY_W-1:0]};
                state_d   = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            snd_addr_q <= '0;
            rcv_addr_q <= '0;
            amount_q   <= '0;
            snd_word_q <= '0;
            rcv_word_q <= '0;
            status_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            snd_addr_q <= snd_addr_d;
            rcv_addr_q <= rcv_addr_d;
            amount_q   <= amount_d;
            snd_word_q <= snd_word_d;
            rcv_word_q <= rcv_word_d;
            status_q   <= status_d;
        end
    end
endmodule

// File: tb/tb_ledger_writer.sv
// Bench for ledger_writer: synchronous RAM model plus a transaction-level reference ledger.
module tb_ledger_writer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  sender_addr = '0, receiver_addr = '0;
    logic [7:0]  amount = '0;
    logic [4:0]  mem_addr;
    logic [11:0] mem_wdata, mem_rdata;
    logic        mem_we, busy, done;
    logic [1:0]  status;

    ledger_writer dut (
        .clock(clock), .reset(reset), .start(start),
        .sender_addr(sender_addr), .receiver_addr(receiver_addr), .amount(amount),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .status(status)
    );

    always #5 clock = ~clock;

    logic [11:0] mem [32];
    logic [11:0] ref_mem [32];
    int cyc = 0;
    int done_cnt = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct { int c; logic [4:0] a; logic [11:0] d; } wr_t;
    wr_t wrs[$];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(negedge clock) begin
        if (mem_we) wrs.push_back('{cyc, mem_addr, mem_wdata});
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int a, input logic [11:0] w);
        mem[a] = w;
        ref_mem[a] = w;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_we"}, 32'(mem_we), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // One transfer, checked against the ledger rules; optionally fires a second start while busy.
    task automatic run_txn(input string tag, input int s, input int r, input int amt, input bit extra);
        int st, d_cyc, ms, mr, exp_lat, exp_st;
        bit found;
        wr_t exp_w[$];
        ms = int'(ref_mem[s][7:0]);
        mr = int'(ref_mem[r][7:0]);
        if (s == r) exp_st = 3;
        else if (ms < amt) exp_st = 1;
        else if (mr + amt > 255) exp_st = 2;
        else exp_st = 0;
        @(negedge clock);
        wrs.delete();
        done_cnt = 0;
        start = 1'b1;
        sender_addr = 5'(s);
        receiver_addr = 5'(r);
        amount = 8'(amt);
        st = cyc;
        if (exp_st == 0) begin
            exp_w.push_back('{st + 5, 5'(s), {ref_mem[s][11:8], 8'(ms - amt)}});
            exp_w.push_back('{st + 6, 5'(r), {ref_mem[r][11:8], 8'(mr + amt)}});
            ref_mem[s][7:0] = 8'(ms - amt);
            ref_mem[r][7:0] = 8'(mr + amt);
        end
        exp_lat = (exp_st == 0) ? 7 : 5;
        @(negedge clock);
        start = 1'b0;
        found = 1'b0;
        d_cyc = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (extra && i == 1) begin
                start = 1'b1; sender_addr = 5'd0; receiver_addr = 5'd1; amount = 8'd0;
            end
            if (i == 2) start = 1'b0;
            if (done) begin
                found = 1'b1;
                d_cyc = cyc;
            end else begin
                @(negedge clock);
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(found), 1);
        chk({tag, "_done_lat"}, 32'(d_cyc - st), 32'(exp_lat));
        chk({tag, "_status"}, 32'(status), 32'(exp_st));
        repeat (3) @(negedge clock);
        chk({tag, "_done_pulses"}, 32'(done_cnt), 1);
        chk({tag, "_status_held"}, 32'(status), 32'(exp_st));
        chk({tag, "_nwrites"}, 32'(wrs.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < wrs.size(); i++) begin
            chk({tag, "_wr_cyc"}, 32'(wrs[i].c - st), 32'(exp_w[i].c - st));
            chk({tag, "_wr_addr"}, 32'(wrs[i].a), 32'(exp_w[i].a));
            chk({tag, "_wr_data"}, 32'(wrs[i].d), 32'(exp_w[i].d));
        end
        chk({tag, "_mem_snd"}, 32'(mem[s]), 32'(ref_mem[s]));
        chk({tag, "_mem_rcv"}, 32'(mem[r]), 32'(ref_mem[r]));
    endtask

    initial begin
        int st, s, r, amt;
        for (int i = 0; i < 32; i++) set_word(i, 12'($urandom));
        repeat (3) @(negedge clock);
        chk("rst_status", 32'(status), 0);
        chk_idle_outputs("rst");
        reset = 1'b0;
        repeat (5) @(negedge clock);
        chk_idle_outputs("idle5");
        chk("idle5_status", 32'(status), 0);

        set_word(3, 12'h164);
        set_word(7, 12'h20A);
        run_txn("basic", 3, 7, 40, 1'b0);
        chk("basic_m3", 32'(mem[3]), 32'h13C);
        chk("basic_m7", 32'(mem[7]), 32'h232);

        set_word(3, 12'h105);
        run_txn("nofunds", 3, 7, 6, 1'b0);
        run_txn("exactbal", 3, 7, 5, 1'b0);
        chk("exactbal_m3", 32'(mem[3]), 32'h100);

        set_word(3, 12'h164);
        set_word(7, 12'h2FA);
        run_txn("ovf", 3, 7, 6, 1'b0);
        run_txn("max255", 3, 7, 5, 1'b0);
        chk("max255_m7", 32'(mem[7]), 32'h2FF);
        run_txn("amt0", 3, 7, 0, 1'b0);

        run_txn("self", 4, 4, 1, 1'b1);
        run_txn("busystart", 3, 9, 2, 1'b1);

        // Reset during WR_SND: the sender write lands, the receiver write never happens.
        set_word(10, 12'h350);
        set_word(11, 12'h410);
        @(negedge clock);
        wrs.delete();
        start = 1'b1; sender_addr = 5'd10; receiver_addr = 5'd11; amount = 8'd16;
        st = cyc;
        @(negedge clock);
        start = 1'b0;
        while (cyc < st + 5) @(negedge clock);
        chk("rstmid_we", 32'(mem_we), 1);
        reset = 1'b1;
        ref_mem[10] = 12'h340;
        @(negedge clock);
        chk_idle_outputs("rstmid");
        chk("rstmid_status", 32'(status), 0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("rstmid_nwrites", 32'(wrs.size()), 1);
        chk("rstmid_m10", 32'(mem[10]), 32'h340);
        chk("rstmid_m11", 32'(mem[11]), 32'h410);
        run_txn("afterrst", 10, 11, 16, 1'b0);

        for (int k = 0; k < 14; k++) begin
            s = int'($urandom_range(0, 31));
            r = (k % 7 == 6) ? s : int'($urandom_range(0, 31));
            amt = (k % 3 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 60));
            run_txn("rand", s, r, amt, k[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ledger_writer.md
Name: ledger_writer

Overview:
- Write-back end of the transaction path: once a transfer has passed amount/key verification, this block reads the sender and receiver records from player memory. It debits the sender, credits the receiver, and writes both records back.
- Memory word is 12 bits: [11:8] record tag (process/key field), [7:0] money. The tag is preserved unchanged on every write.
- Sits between the verification controller (start/done handshake) and the player memory port.

Parameters:
- ADDR_W, 5, player memory address width (32 records)
- MONEY_W, 8, money field width, bits [MONEY_W-1:0] of the word
- TAG_W, 4, tag field width, bits [11:8]

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- sender_addr  in  ADDR_W  sender record address
- receiver_addr  in  ADDR_W  receiver record address
- amount  in  MONEY_W  transfer amount
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  TAG_W+MONEY_W  write data
- mem_we  out  1  write enable, one cycle per write
- mem_rdata  in  TAG_W+MONEY_W  read data, valid the cycle after mem_addr is presented (synchronous RAM)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- status  out  2  00 ok, 01 insufficient funds, 10 receiver overflow, 11 self-transfer; held until the next start

Behaviour:
- Reset: state=IDLE; mem_addr=0, mem_wdata=0, mem_we=0, busy=0, done=0, status=00; latched registers cleared. Reset mid-transfer aborts immediately, and no further writes are issued. A write already issued in the same cycle as reset is not retracted.
- IDLE: on start=1, latch sender_addr, receiver_addr, amount; go to RD_SND. start while busy is ignored (not queued).
- RD_SND (start+1): mem_addr=sender; go to RD_RCV.
- RD_RCV (start+2): mem_addr=receiver; capture mem_rdata as sender word; go to WAIT_RCV.
- WAIT_RCV (start+3): capture mem_rdata as receiver word; go to CHECK.
- CHECK (start+4): evaluate in priority order:
  - sender==receiver -> status=11
  - else sender money < amount (unsigned) -> status=01
  - else receiver money + amount > 2^MONEY_W-1 (9-bit sum, carry set) -> status=10
  - else status=00
  - Any error goes to DONE with no writes; ok goes to WR_SND.
- WR_SND (start+5): mem_addr=sender, mem_we=1, mem_wdata={sender tag, sender money - amount}.
- WR_RCV (start+6): mem_addr=receiver, mem_we=1, mem_wdata={receiver tag, receiver money + amount[MONEY_W-1:0]}.
- DONE: done=1 for exactly one cycle, then IDLE. Success: done at start+7. Error: done at start+5.
- mem_we is 0 in all states except WR_SND/WR_RCV. mem_wdata may be don't-care when mem_we=0, but is driven 0 in IDLE.
- amount=0 is legal: both records are rewritten unchanged, status=00.
- Exact-balance debit (money==amount) is legal and leaves sender at 0.
- Receiver reaching exactly 255 is legal; 256 or more is overflow.
- start asserted in the same cycle done is high: ignored, because the FSM is in DONE, not IDLE. A new start is accepted the cycle after done.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, busy=0, no mem_we.
- mem[3]=0x164 (tag 1, 100), mem[7]=0x20A (tag 2, 10); start sender=3, receiver=7, amount=40 -> writes mem[3]=0x13C at start+5 and mem[7]=0x232 at start+6; done at start+7; status=00.
- mem[3]=0x105; amount=6 -> no mem_we at any cycle; done at start+5; status=01. Repeat with amount=5 -> mem[3]=0x100, status=00.
- Receiver mem[7]=0x2FA (250); amount=6 with sufficient sender funds -> no writes, status=10. amount=5 -> mem[7]=0x2FF, status=00.
- sender=receiver=4 -> no writes, status=11, done at start+5. A second start while busy -> ignored, exactly one done pulse.
- Assert reset at start+5 (WR_SND) -> next cycle IDLE with all outputs 0 and no WR_RCV write. A fresh start afterwards completes normally.
